adder_tree_ctrl: RTL
====================

# adder_tree_ctrl

Frame-level sequencer for the line adder tree. It accepts one line of squared pixel differences per handshake and forwards it to the adder tree. It also collects the tree's line sum one cycle later and accumulates NUM_LINES line sums into a frame sum, which it presents with a valid/ready handshake. It sits between the line producer (difference/square stage) and the frame result consumer, and owns the adder tree instance's input.

## Interface

- PIXEL_SIZE, 8, pixel width; tree elements are 2*PIXEL_SIZE bits
- LINE_SIZE, 16, elements per line (tree width)
- NUM_LINES, 16, lines per frame, ≥1
- Derived: LINE_W = $clog2(LINE_SIZE)+2*PIXEL_SIZE; SUM_W = LINE_W+$clog2(NUM_LINES); CNT_W = $clog2(NUM_LINES+1)

- CLK  in  1  clock, all logic on posedge
- RST_N  in  1  reset, synchronous, active-low
- start  in  1  request new frame; sampled only in IDLE
- line_valid  in  1  producer has a line on line_in
- line_in  in  [2*PIXEL_SIZE-1:0] x LINE_SIZE  line elements
- line_ready  out  1  controller accepts line this cycle
- tree_line_out  out  [2*PIXEL_SIZE-1:0] x LINE_SIZE  to adder tree line input
- tree_sum_in  in  LINE_W  from adder tree sum output (valid 1 cycle after drive)
- frame_sum  out  SUM_W  accumulated frame sum
- frame_valid  out  1  frame_sum is final
- frame_ready  in  1  consumer takes frame_sum
- busy  out  1  state != IDLE
- line_cnt  out  CNT_W  lines accepted in current frame

## Operation

- States: IDLE, FEED, DONE.
- IDLE:
  - line_ready=0 and frame_valid=0.
  - If start=1: clear acc and line_cnt, then go to FEED.
  - line_valid is ignored.
- FEED:
  - line_ready = (line_cnt < NUM_LINES).
  - A line is accepted when line_valid & line_ready. On acceptance: line_cnt+1, pend<=1; otherwise pend<=0.
  - tree_line_out = line_in combinationally during an accepted beat, all-zero otherwise. The tree therefore registers only accepted lines.
  - When pend=1: acc <= acc + zero-extended tree_sum_in.
  - Exit condition: line_cnt==NUM_LINES and pend=1. On that edge, do the final accumulation and go to DONE.
- DONE:
  - frame_valid=1; frame_sum=acc, held stable; line_ready=0.
  - frame_valid & frame_ready: go to IDLE. frame_valid drops; frame_sum keeps its value until the next start.
- start is ignored in FEED and DONE; it is not queued.
- Width rule: no overflow or saturation is possible by construction. Max line sum LINE_SIZE*(2^(2P)-1) fits LINE_W; max frame sum fits SUM_W.
- Reset (RST_N=0 at posedge), including mid-frame:
  - State IDLE; acc, line_cnt and pend cleared; in-flight tree sum discarded.
  - Outputs: line_ready=0, frame_valid=0, busy=0, frame_sum=0, line_cnt=0, tree_line_out=0.

## Timing

- start sampled at edge s → FEED from s; line_ready=1 in cycle after s.
- Line accepted at edge k → tree registers it at k → tree_sum_in valid in cycle k..k+1 → accumulated at edge k+1.
- Back-to-back lines are sustained: one line per cycle; accumulation overlaps the next acceptance.
- Last line accepted at edge k → DONE at edge k+1 → frame_valid=1 during the following cycle.
- Minimum frame period, continuous line_valid and frame_ready=1: lines at edges s+1..s+NUM_LINES; frame_valid is visible after edge s+NUM_LINES+1; IDLE after edge s+NUM_LINES+2.
- line_ready never depends combinationally on line_valid. frame_valid never depends combinationally on frame_ready.

## Test plan

1. PIXEL_SIZE=8, LINE_SIZE=4, NUM_LINES=3; start, then three back-to-back lines of all 1s → line_cnt steps 1,2,3; frame_sum=12; frame_valid high exactly after edge s+4.
2. Same configuration, all elements 65535 → frame_sum=786420 (SUM_W=20), no wrap. Then next frame with all 0s → frame_sum=0, proving acc is cleared on start.
3. line_valid with gaps (lines 1,2,3 = {1,2,3,4},{0,0,0,5},{7,0,0,0}), frame_ready low for 5 cycles in DONE → frame_sum=22 held stable, line_ready=0, start pulses ignored. frame_valid drops one cycle after frame_ready=1.
4. RST_N low for one edge after 2 of 3 lines accepted → all outputs 0 and IDLE. A new frame of all-2 lines → frame_sum=24 with no leftover contribution.
5. line_valid=1 in IDLE with no start → line_ready=0, tree_line_out all-zero, line_cnt=0, busy=0. start asserted during FEED → no restart, line_cnt unaffected.

Source files
------------

// File: rtl/adder_tree_ctrl.sv
// Frame sequencer for the line adder tree: gates accepted lines into the tree,
// accumulates each returned line sum, and hands the frame sum to the consumer.
module adder_tree_ctrl #(
  parameter int PIXEL_SIZE = 8,
  parameter int LINE_SIZE  = 16,
  parameter int NUM_LINES  = 16,
  localparam int ELEM_W = 2*PIXEL_SIZE,
  localparam int LINE_W = $clog2(LINE_SIZE) + ELEM_W,
  localparam int SUM_W  = LINE_W + $clog2(NUM_LINES),
  localparam int CNT_W  = $clog2(NUM_LINES+1)
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        start,
  input  logic                        line_valid,
  input  logic [LINE_SIZE*ELEM_W-1:0] line_in,
  output logic                        line_ready,
  output logic [LINE_SIZE*ELEM_W-1:0] tree_line_out,
  input  logic [LINE_W-1:0]           tree_sum_in,
  output logic [SUM_W-1:0]            frame_sum,
  output logic                        frame_valid,
  input  logic                        frame_ready,
  output logic                        busy,
  output logic [CNT_W-1:0]            line_cnt
);

  typedef enum logic [1:0] {IDLE, FEED, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_LINES);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             vld_p1;
  logic [SUM_W-1:0] acc;

  // Line sums are bounded by construction, so plain zero-extended addition never wraps.
  function automatic logic [SUM_W-1:0] acc_add(input logic [SUM_W-1:0] a,
                                               input logic [LINE_W-1:0] s);
    return a + SUM_W'(s);
  endfunction

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    line_ready  = 1'b0;
    frame_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = FEED;
      end
      FEED: begin
        line_ready = (line_cnt < CNT_FULL);
        if ((line_cnt == CNT_FULL) && vld_p1) state_nxt = DONE;
      end
      DONE: begin
        frame_valid = 1'b1;
        if (frame_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept        = line_valid & line_ready;
  assign tree_line_out = accept ? line_in : '0;
  assign busy          = (state != IDLE);
  assign frame_sum     = acc;

  // stage p0 -> p1: accepted line enters the tree; its sum returns one cycle later
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      acc      <= '0;
      line_cnt <= '0;
      vld_p1   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          vld_p1 <= 1'b0;
          if (start) begin
            acc      <= '0;
            line_cnt <= '0;
          end
        end
        FEED: begin
          vld_p1 <= accept;
          if (accept) line_cnt <= line_cnt + CNT_W'(1);
          if (vld_p1) acc <= acc_add(acc, tree_sum_in);
        end
        default: vld_p1 <= 1'b0;
      endcase
    end
  end

  a_cnt_bound: assert property (@(posedge CLK) disable iff (!RST_N) line_cnt <= CNT_FULL);
  a_valid_idle: assert property (@(posedge CLK) disable iff (!RST_N)
                                 (state == IDLE) |-> (!line_ready && !frame_valid));

endmodule
